dclk_monitor: RTL
=================

// Module: dclk_monitor
// PURPOSE
//  Receiving-end checker for the divided core clock Dclk produced from clk_small.
//  Samples the divided clock in the clk_small domain and detects its rising edges.
//  Measures period and high time in clk_small cycles and declares lock after N good periods.
//  Flags bad or stalled periods so the fetch/memory phase logic only trusts Dclk while locked.
// PARAMETERS
//  DIV_RATIO  2  expected clk_small cycles per Dclk period; even, >=2
//  LOCK_CNT   4  consecutive good periods required to assert locked; 1..255
//  CNT_W      8  width of period/high-time counters; must hold 2*DIV_RATIO
//  ERRCNT_W   8  width of saturating error counter
// PORTS
//  clk_small   in   1         fast clock; all logic on posedge
//  rst         in   1         synchronous, active-high reset
//  en          in   1         monitor enable; 0 forces IDLE
//  dclk_in     in   1         divided clock under test, sampled as data
//  rise_pulse  out  1         1-cycle pulse per detected Dclk rising edge
//  locked      out  1         1 only in state LOCKED
//  err_pulse   out  1         1-cycle pulse per bad period or timeout
//  period      out  CNT_W     last measured period in clk_small cycles
//  err_count   out  ERRCNT_W  saturating error count (macro-dependent)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; all outputs 0; counters 0; sample flops 0.
//  - Sampling: s0<=dclk_in, s1<=s0; rise = s0 & ~s1 (combinational).
//  - cnt: cleared when rise=1, else +1, saturates at 2*DIV_RATIO. hi: same, +s0.
//  - Measured period = cnt+1; measured high time = hi+s0, both taken on rise.
//  - Good period: measured period == DIV_RATIO and high time == DIV_RATIO/2.
//  - All outputs are registered.
//    - rise_pulse goes high 2 cycles after the first dclk_in sample seen high.
//    - period, err_pulse and locked update on that same edge.
//  - FSM (2-bit):
//    IDLE: en=1 -> WAIT_EDGE.
//    WAIT_EDGE: first rise -> ACQUIRE, good=0, no measurement.
//    ACQUIRE: good rise -> good+1; at good==LOCK_CNT -> LOCKED.
//    LOCKED: good rise -> stay.
//  - Error, any of ACQUIRE/LOCKED:
//    - Bad period: err_pulse=1, good=0 -> ACQUIRE.
//    - Timeout (cnt reaches 2*DIV_RATIO with no rise): err_pulse=1 -> WAIT_EDGE. One pulse per stall.
//  - en=0 in any state -> IDLE next cycle.
//    - locked, rise_pulse and err_pulse go to 0; period and err_count hold.
//  - rst wins over en. Errors and rise in the same cycle give err_pulse=1 and rise_pulse=1.
//  - Reset mid-operation behaves exactly as power-up reset.
// CONFIGURATION
//  DCLK_MON_ERRCNT_EN defined:
//    - err_count += 1 on every err_pulse, saturates at all-ones.
//    - Cleared only by rst.
//  DCLK_MON_ERRCNT_EN undefined: no counter flops; err_count tied to 0; port kept.
// STRUCTURE
//  - dclk_mon_pkg: state typedef {IDLE=0, WAIT_EDGE=1, ACQUIRE=2, LOCKED=3}; default constants.
//  - Sub-module dclk_edge_det: s0/s1 flops plus rise/fall outputs, sync reset.
//  - Top holds the counters, FSM and output registers.
// TESTING (DIV_RATIO=2, LOCK_CNT=4)
//  1. rst=1 for 3 cycles with dclk_in toggling -> all outputs 0, err_count=0.
//  2. en=1, dclk_in toggles every cycle.
//     - Expect rise_pulse every 2 cycles and period=2.
//     - locked=1 after the 5th rise_pulse; err_pulse never 1.
//  3. While locked, hold dclk_in high 2 cycles once.
//     - Expect period=3, err_pulse for 1 cycle, locked=0.
//     - Relock after 4 good periods; err_count=1 with macro.
//  4. While locked, hold dclk_in low for 6 cycles.
//     - Expect err_pulse once at cnt=4 and locked=0.
//     - The next rise gives no err; relock after 4 more periods.
//  5. rst=1 for 1 cycle while LOCKED with err_count=3 -> next cycle all outputs 0, err_count=0.
//  6. en=0 while locked.
//     - Expect locked=0 next cycle; period and err_count hold.
//     - Build without DCLK_MON_ERRCNT_EN -> err_count stays 0.

Source files
------------

// File: rtl/dclk_mon_pkg.sv
// Shared state encoding and default parameters for the divided-clock monitor.
package dclk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        ACQUIRE   = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    localparam int DEF_DIV_RATIO = 2;
    localparam int DEF_LOCK_CNT  = 4;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_ERRCNT_W  = 8;

endpackage

// File: rtl/dclk_edge_det.sv
// Samples the divided clock as data in the clk_small domain and flags its edges.
module dclk_edge_det (
    input  logic clk_small,
    input  logic rst,
    input  logic din,
    output logic s0,
    output logic rise,
    output logic fall
);

    logic s1;

    always_ff @(posedge clk_small) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= din;
            s1 <= s0;
        end
    end

    assign rise = s0 & ~s1;
    assign fall = ~s0 & s1;

endmodule

// File: rtl/dclk_monitor.sv
// Divided-clock monitor: period/high-time measurement, lock acquisition, stall detection.
// Optional saturating error counter enabled by defining DCLK_MON_ERRCNT_EN.
//
// state     | meaning
// IDLE      | monitor disabled, nothing trusted
// WAIT_EDGE | enabled, waiting for a first rising edge to start measuring from
// ACQUIRE   | counting consecutive good periods towards lock
// LOCKED    | LOCK_CNT good periods seen; Dclk is trusted
module dclk_monitor
    import dclk_mon_pkg::*;
#(
    parameter int DIV_RATIO = DEF_DIV_RATIO,
    parameter int LOCK_CNT  = DEF_LOCK_CNT,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int ERRCNT_W  = DEF_ERRCNT_W
) (
    input  logic                clk_small,
    input  logic                rst,
    input  logic                en,
    input  logic                dclk_in,
    output logic                rise_pulse,
    output logic                locked,
    output logic                err_pulse,
    output logic [CNT_W-1:0]    period,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * DIV_RATIO);
    localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV_RATIO);
    localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(DIV_RATIO / 2);
    localparam logic [7:0]       LOCK_C  = 8'(LOCK_CNT);

    logic             s0;
    logic             rise;
    logic             fall_unused;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             good_period;
    logic             timeout;
    logic             measuring;
    logic             err_set;
    logic [7:0]       good;
    state_t           state;

    dclk_edge_det u_edge (
        .clk_small (clk_small),
        .rst       (rst),
        .din       (dclk_in),
        .s0        (s0),
        .rise      (rise),
        .fall      (fall_unused)
    );

    // Counters run regardless of state so a measurement is ready on any edge.
    always_ff @(posedge clk_small) begin
        if (rst) begin
            cnt <= '0;
            hi  <= '0;
        end else if (rise) begin
            cnt <= '0;
            hi  <= '0;
        end else begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (s0 && (hi != CNT_MAX)) hi <= hi + CNT_W'(1);
        end
    end

    assign meas_period = cnt + CNT_W'(1);
    assign meas_high   = hi + CNT_W'(s0);
    assign good_period = (meas_period == DIV_C) && (meas_high == HALF_C);
    assign timeout     = !rise && (cnt == CNT_MAX);
    assign measuring   = (state == ACQUIRE) || (state == LOCKED);
    assign err_set     = en && measuring && ((rise && !good_period) || timeout);

    always_ff @(posedge clk_small) begin
        if (rst) begin
            state      <= IDLE;
            good       <= '0;
            rise_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            locked     <= 1'b0;
            period     <= '0;
        end else if (!en) begin
            state      <= IDLE;
            good       <= '0;
            rise_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            rise_pulse <= rise;
            err_pulse  <= err_set;
            case (state)
                IDLE: state <= WAIT_EDGE;
                WAIT_EDGE: begin
                    if (rise) begin
                        state <= ACQUIRE;
                        good  <= '0;
                    end
                end
                ACQUIRE: begin
                    if (rise) begin
                        period <= meas_period;
                        if (good_period) begin
                            good <= good + 8'd1;
                            if (good + 8'd1 == LOCK_C) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good <= '0;
                        end
                    end else if (timeout) begin
                        state <= WAIT_EDGE;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        period <= meas_period;
                        if (!good_period) begin
                            good   <= '0;
                            state  <= ACQUIRE;
                            locked <= 1'b0;
                        end
                    end else if (timeout) begin
                        state  <= WAIT_EDGE;
                        locked <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCLK_MON_ERRCNT_EN
    always_ff @(posedge clk_small) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_set && (err_count != '1)) begin
            err_count <= err_count + ERRCNT_W'(1);
        end
    end
`else
    assign err_count = '0;
`endif

endmodule
